iir_result_capture: RTL and testbench

//  Capture sink at the output of the IIR filter top. Stores the filter output

---
 rtl/iir_cap_pkg.sv | 19 +
 rtl/iir_cap_sdp_ram.sv | 47 ++++
 rtl/iir_result_capture.sv | 186 ++++++++++++++++++
 tb/tb_iir_result_capture.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_cap_pkg.sv
// ----------------------------------------------------------------------------
// iir_cap_pkg
//   Shared definitions for the IIR result capture sink: default sample width
//   and buffer depth (kept in step with the filter top) and the capture FSM
//   state encoding.
// ----------------------------------------------------------------------------
package iir_cap_pkg;

   localparam int CAP_DATA_W = 24;
   localparam int CAP_DEPTH  = 2048;
   localparam int CAP_ADDR_W = 11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } cap_state_t;

endpackage

// File: rtl/iir_cap_sdp_ram.sv
// ----------------------------------------------------------------------------
// iir_cap_sdp_ram
//   Simple dual-port sample buffer: one write port, one registered read port.
//   The array has no reset so it maps onto block RAM. The read register only
//   loads when re is high, so it holds its last value between reads.
// Ports
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable
//   raddr  read address
//   rdata  registered read data (valid the cycle after re)
// ----------------------------------------------------------------------------
module iir_cap_sdp_ram #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rdata_r;

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port, holds value while re is low.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/iir_result_capture.sv
// ----------------------------------------------------------------------------
// iir_result_capture
//   Capture sink at the IIR filter output. Stores the sample stream into an
//   on-chip buffer, tracks peak magnitude and offers a read-back port once
//   capture is complete.
// Ports
//   clk, rst_n   clock, async active-low reset
//   arm          pulse: clear status and (re)start capture
//   stop         pulse: end capture early (only acts in CAPTURE)
//   in_data      signed sample, in_valid qualifies one sample per cycle
//   cap_busy     capturing
//   cap_done     capture finished, buffer readable
//   cap_count    samples stored (0..DEPTH)
//   overflow     sticky: sample offered while DONE
//   peak_abs     max |in_data| over stored samples
//   rd_req       read request (DONE only), rd_addr read address
//   rd_data      read data, rd_valid one-cycle qualifier
//   rd_oob       with rd_valid: address beyond stored samples, data forced 0
// ----------------------------------------------------------------------------
module iir_result_capture
   import iir_cap_pkg::*;
#(
   parameter int DATA_W = CAP_DATA_W,
   parameter int DEPTH  = CAP_DEPTH,
   parameter int ADDR_W = CAP_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              stop,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              cap_busy,
   output logic              cap_done,
   output logic [ADDR_W:0]   cap_count,
   output logic              overflow,
   output logic [DATA_W-1:0] peak_abs,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_oob
);

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);

   // Two's complement magnitude at full width; the most negative value maps
   // to 2^(DATA_W-1), which still fits as an unsigned DATA_W number.
   function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] x);
      logic [DATA_W-1:0] one_v;
      one_v = {{(DATA_W-1){1'b0}}, 1'b1};
      return x[DATA_W-1] ? (~x + one_v) : x;
   endfunction

   cap_state_t        state_r, state_nxt_s;
   logic [ADDR_W:0]   count_r;
   logic [DATA_W-1:0] peak_r;
   logic [DATA_W-1:0] mag_s;
   logic [DATA_W-1:0] ram_q_s;
   logic              ovf_r, busy_r, done_r;
   logic              rd_valid_r, rd_oob_r, rd_zero_r;
   logic              wr_en_s, rd_acc_s, ovf_set_s, rd_oob_s;

   assign mag_s    = abs_mag(in_data);
   assign rd_oob_s = ({1'b0, rd_addr} >= count_r);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: arm dominates stop; the write filling the buffer ends capture.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (arm) state_nxt_s = CAPTURE;
            else     state_nxt_s = IDLE;
         end
         CAPTURE: begin
            if (arm)                                  state_nxt_s = CAPTURE;
            else if (stop)                            state_nxt_s = DONE;
            else if (in_valid && (count_r == LAST_IDX)) state_nxt_s = DONE;
            else                                      state_nxt_s = CAPTURE;
         end
         DONE: begin
            if (arm) state_nxt_s = CAPTURE;
            else     state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs: per-cycle write, overflow and read-accept strobes.
   always_comb begin
      wr_en_s   = 1'b0;
      rd_acc_s  = 1'b0;
      ovf_set_s = 1'b0;
      case (state_r)
         CAPTURE: begin
            wr_en_s = in_valid & ~arm;
         end
         DONE: begin
            rd_acc_s  = rd_req & ~arm;
            ovf_set_s = in_valid & ~arm;
         end
         default: begin
            wr_en_s   = 1'b0;
            rd_acc_s  = 1'b0;
            ovf_set_s = 1'b0;
         end
      endcase
   end

   // Capture status: count, peak, sticky overflow, busy/done flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {(ADDR_W+1){1'b0}};
         peak_r  <= {DATA_W{1'b0}};
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s == CAPTURE);
         done_r <= (state_nxt_s == DONE);
         if (arm) begin
            count_r <= {(ADDR_W+1){1'b0}};
            peak_r  <= {DATA_W{1'b0}};
            ovf_r   <= 1'b0;
         end else begin
            if (wr_en_s) begin
               count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
               if (mag_s > peak_r) begin
                  peak_r <= mag_s;
               end
            end
            if (ovf_set_s) begin
               ovf_r <= 1'b1;
            end
         end
      end
   end

   // Read-side qualifiers; rd_zero_r masks RAM output for out-of-range reads
   // and before the first read after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_r <= 1'b0;
         rd_oob_r   <= 1'b0;
         rd_zero_r  <= 1'b1;
      end else begin
         rd_valid_r <= rd_acc_s;
         rd_oob_r   <= rd_acc_s & rd_oob_s;
         if (rd_acc_s) begin
            rd_zero_r <= rd_oob_s;
         end
      end
   end

   iir_cap_sdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en_s),
      .waddr (count_r[ADDR_W-1:0]),
      .wdata (in_data),
      .re    (rd_acc_s & ~rd_oob_s),
      .raddr (rd_addr),
      .rdata (ram_q_s)
   );

   assign cap_busy  = busy_r;
   assign cap_done  = done_r;
   assign cap_count = count_r;
   assign overflow  = ovf_r;
   assign peak_abs  = peak_r;
   assign rd_valid  = rd_valid_r;
   assign rd_oob    = rd_oob_r;
   assign rd_data   = rd_zero_r ? {DATA_W{1'b0}} : ram_q_s;

endmodule

// File: tb/tb_iir_result_capture.sv
// ----------------------------------------------------------------------------
// tb_iir_result_capture
//   Directed bench for iir_result_capture. Status outputs are compared
//   directly; read-back results go through an expected-value queue that a
//   separate monitor drains whenever rd_valid is seen.
// ----------------------------------------------------------------------------
module tb_iir_result_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        arm, stop, in_valid, rd_req;
   logic [23:0] in_data;
   logic [10:0] rd_addr;
   logic        cap_busy, cap_done, overflow, rd_valid, rd_oob;
   logic [11:0] cap_count;
   logic [23:0] peak_abs, rd_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [23:0] data;
      logic        oob;
   } rd_exp_t;

   rd_exp_t exp_q[$];

   always #5 clk = ~clk;

   iir_result_capture dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .arm       (arm),
      .stop      (stop),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .cap_busy  (cap_busy),
      .cap_done  (cap_done),
      .cap_count (cap_count),
      .overflow  (overflow),
      .peak_abs  (peak_abs),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_oob    (rd_oob)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] x, input logic stop_v);
      in_valid = 1'b1;
      in_data  = x;
      stop     = stop_v;
      tick();
      in_valid = 1'b0;
      stop     = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic stop_pulse();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   // Issue one read cycle (rd_req left high for back-to-back use).
   task automatic rd_one(input logic [10:0] a, input logic [23:0] d, input logic oob);
      rd_exp_t e;
      e.data = d;
      e.oob  = oob;
      exp_q.push_back(e);
      rd_req  = 1'b1;
      rd_addr = a;
      tick();
   endtask

   task automatic rd_idle();
      rd_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  32'(cap_busy),  32'd0);
      chk({tag, "_done"},  32'(cap_done),  32'd0);
      chk({tag, "_count"}, 32'(cap_count), 32'd0);
      chk({tag, "_ovf"},   32'(overflow),  32'd0);
      chk({tag, "_peak"},  32'(peak_abs),  32'd0);
      chk({tag, "_rdv"},   32'(rd_valid),  32'd0);
      chk({tag, "_rdd"},   32'(rd_data),   32'd0);
      chk({tag, "_oob"},   32'(rd_oob),    32'd0);
   endtask

   // Read monitor: every rd_valid must match the oldest expected entry.
   initial begin
      rd_exp_t e;
      forever begin
         @(negedge clk);
         if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_unexpected rd_valid=1 data=%0d with no request pending", rd_data);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", 32'(rd_data), 32'(e.data));
               chk("rd_oob",  32'(rd_oob),  32'(e.oob));
            end
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      arm      = 1'b0;
      stop     = 1'b0;
      in_valid = 1'b0;
      in_data  = 24'd0;
      rd_req   = 1'b0;
      rd_addr  = 11'd0;
      repeat (3) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // IDLE: reads, stop and samples are all ignored.
      rd_req  = 1'b1;
      rd_addr = 11'd0;
      tick();
      tick();
      rd_idle();
      stop_pulse();
      chk("idle_stop_done", 32'(cap_done), 32'd0);
      send(24'd5, 1'b0);
      chk("idle_count", 32'(cap_count), 32'd0);
      chk("idle_ovf",   32'(overflow),  32'd0);

      // Full capture of 0..2047.
      do_arm();
      chk("arm_busy", 32'(cap_busy), 32'd1);
      for (int i = 0; i < 2047; i++) send(24'(i), 1'b0);
      chk("full_pre_done",  32'(cap_done),  32'd0);
      chk("full_pre_count", 32'(cap_count), 32'd2047);
      send(24'd2047, 1'b0);
      chk("full_done",  32'(cap_done),  32'd1);
      chk("full_busy",  32'(cap_busy),  32'd0);
      chk("full_count", 32'(cap_count), 32'd2048);
      chk("full_ovf",   32'(overflow),  32'd0);
      chk("full_peak",  32'(peak_abs),  32'd2047);
      rd_one(11'd2047, 24'd2047, 1'b0);
      rd_one(11'd0,    24'd0,    1'b0);
      rd_one(11'd1000, 24'd1000, 1'b0);
      rd_idle();

      // Re-arm with a sample in the arm cycle (must not be stored), stop with 6th.
      arm      = 1'b1;
      in_valid = 1'b1;
      in_data  = 24'd999;
      tick();
      arm      = 1'b0;
      in_valid = 1'b0;
      chk("rearm_count", 32'(cap_count), 32'd0);
      chk("rearm_busy",  32'(cap_busy),  32'd1);
      chk("rearm_done",  32'(cap_done),  32'd0);
      chk("rearm_peak",  32'(peak_abs),  32'd0);
      send(24'd100,     1'b0);
      send(24'h800000,  1'b0);
      send(24'd50,      1'b0);
      send(24'd1,       1'b0);
      send(24'd2,       1'b0);
      send(24'd3,       1'b1);
      chk("stop_count", 32'(cap_count), 32'd6);
      chk("stop_done",  32'(cap_done),  32'd1);
      chk("stop_peak",  32'(peak_abs),  32'd8388608);
      rd_one(11'd2, 24'd50,  1'b0);
      rd_one(11'd9, 24'd0,   1'b1);
      rd_one(11'd0, 24'd100, 1'b0);
      rd_one(11'd1, 24'h800000, 1'b0);
      rd_one(11'd5, 24'd3,   1'b0);
      rd_one(11'd6, 24'd0,   1'b1);
      rd_idle();

      // Samples in DONE set sticky overflow without storing.
      send(24'd7, 1'b0);
      send(24'd8, 1'b0);
      send(24'd9, 1'b0);
      chk("ovf_set",   32'(overflow),  32'd1);
      chk("ovf_count", 32'(cap_count), 32'd6);
      chk("ovf_done",  32'(cap_done),  32'd1);

      // arm together with rd_req: arm wins, no read result.
      rd_req  = 1'b1;
      rd_addr = 11'd0;
      arm     = 1'b1;
      tick();
      arm     = 1'b0;
      rd_req  = 1'b0;
      chk("arm_clr_ovf",   32'(overflow),  32'd0);
      chk("arm_clr_count", 32'(cap_count), 32'd0);
      chk("arm_clr_busy",  32'(cap_busy),  32'd1);
      tick();
      tick();

      // Small negative peak, stop on its own.
      send(24'hFFFFF9, 1'b0);
      send(24'd3,      1'b0);
      stop_pulse();
      chk("neg_count", 32'(cap_count), 32'd2);
      chk("neg_done",  32'(cap_done),  32'd1);
      chk("neg_peak",  32'(peak_abs),  32'd7);

      // arm and stop together: arm wins.
      arm  = 1'b1;
      stop = 1'b1;
      tick();
      arm  = 1'b0;
      stop = 1'b0;
      chk("armstop_busy", 32'(cap_busy), 32'd1);
      chk("armstop_done", 32'(cap_done), 32'd0);

      // Reset in the middle of a capture.
      for (int i = 0; i < 100; i++) send(24'(i + 500), 1'b0);
      chk("mid_count", 32'(cap_count), 32'd100);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", 32'(cap_busy), 32'd0);

      do_arm();
      send(24'd10, 1'b0);
      send(24'd20, 1'b0);
      send(24'd30, 1'b0);
      send(24'd40, 1'b0);
      chk("re_count_busy", 32'(cap_busy),  32'd1);
      stop_pulse();
      chk("re_count", 32'(cap_count), 32'd4);
      chk("re_done",  32'(cap_done),  32'd1);
      rd_one(11'd0, 24'd10, 1'b0);
      rd_one(11'd1, 24'd20, 1'b0);
      rd_one(11'd2, 24'd30, 1'b0);
      rd_one(11'd3, 24'd40, 1'b0);
      rd_one(11'd4, 24'd0,  1'b1);
      rd_idle();

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      chk("rd_pending", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
